// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: operand magnitudes, shift-add / restoring shift-subtract
// step over a 2*WIDTH+1 accumulator, iteration counter and sign correction.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int AW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2 * WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C  = {{(CNT_W - 1){1'b0}}, 1'b1};

  logic [AW-1:0]      acc_r;
  logic [WIDTH-1:0]   opb_r;
  logic               div_r;
  logic               neg_q_r;
  logic               neg_rem_r;
  logic               div0_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     part_s;
  logic [WIDTH:0]     sum_s;
  logic [AW-1:0]      shl_s;
  logic [WIDTH:0]     trial_s;
  logic [AW-1:0]      acc_nxt_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  // Operand sign flags and magnitudes; 0x80000000 stays 0x80000000 as unsigned.
  always_comb begin
    a_neg_s = is_signed & srca[WIDTH-1];
    b_neg_s = is_signed & srcb[WIDTH-1];
    if (a_neg_s) a_mag_s = ~srca + ONE_W;
    else         a_mag_s = srca;
    if (b_neg_s) b_mag_s = ~srcb + ONE_W;
    else         b_mag_s = srcb;
  end

  // One radix-2 iteration: multiply adds into the upper half then shifts right;
  // divide shifts left and keeps the subtraction only when it does not borrow.
  always_comb begin
    part_s    = acc_r[0] ? {1'b0, opb_r} : {(WIDTH + 1){1'b0}};
    sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + part_s;
    shl_s     = {acc_r[AW-2:0], 1'b0};
    trial_s   = shl_s[AW-1:WIDTH] - {1'b0, opb_r};
    acc_nxt_s = shl_s;
    if (div_r) begin
      if (shl_s[AW-1:WIDTH] >= {1'b0, opb_r}) acc_nxt_s = {trial_s, shl_s[WIDTH-1:1], 1'b1};
      else                                    acc_nxt_s = shl_s;
    end else begin
      acc_nxt_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished accumulator; a zero divisor keeps all-ones quotient.
  always_comb begin
    prod_s = acc_r[2*WIDTH-1:0];
    quo_s  = acc_r[WIDTH-1:0];
    rem_s  = acc_r[2*WIDTH-1:WIDTH];
    res_hi = {WIDTH{1'b0}};
    res_lo = {WIDTH{1'b0}};
    if (div_r) begin
      if (neg_q_r && !div0_r) res_lo = ~quo_s + ONE_W;
      else                    res_lo = quo_s;
      if (neg_rem_r) res_hi = ~rem_s + ONE_W;
      else           res_hi = rem_s;
    end else begin
      if (neg_q_r) prod_s = ~acc_r[2*WIDTH-1:0] + ONE_2W;
      else         prod_s = acc_r[2*WIDTH-1:0];
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
  end

  // Accumulator, operand and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r     <= {AW{1'b0}};
      opb_r     <= {WIDTH{1'b0}};
      div_r     <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else if (load) begin
      div_r     <= is_div;
      neg_q_r   <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
      div0_r    <= is_div & (srcb == {WIDTH{1'b0}});
      opb_r     <= is_div ? b_mag_s : a_mag_s;
      acc_r     <= {{(WIDTH + 1){1'b0}}, (is_div ? a_mag_s : b_mag_s)};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (step) begin
      acc_r     <= acc_nxt_s;
      cnt_r     <= cnt_r + ONE_C;
    end else begin
      acc_r     <= acc_r;
      cnt_r     <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: control FSM, HI/LO registers, MTHI/MTLO and
// flush handling around the iterative muldiv_core datapath.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;

  logic             load_s;
  logic             step_s;
  logic [CNT_W-1:0] cnt_s;
  logic [WIDTH-1:0] res_hi_s;
  logic [WIDTH-1:0] res_lo_s;

  // Accept a MULT/DIV only from IDLE; flush always wins over start.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    if (state_r == S_IDLE && start && !flush && !op[2]) load_s = 1'b1;
    else                                                load_s = 1'b0;
    if (state_r == S_RUN && !flush) step_s = 1'b1;
    else                            step_s = 1'b0;
  end

  muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .step      (step_s),
    .is_div    (op[1]),
    .is_signed (~op[0]),
    .srca      (srca),
    .srcb      (srcb),
    .cnt       (cnt_s),
    .res_hi    (res_hi_s),
    .res_lo    (res_lo_s)
  );

  // Control FSM with registered HI/LO, busy and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_r <= S_RUN;
                busy_r  <= 1'b1;
              end
              OP_MTHI: hi_r    <= srca;
              OP_MTLO: lo_r    <= srca;
              default: state_r <= S_IDLE;
            endcase
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          if (flush) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_s == LAST_CNT) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_FIX: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          if (!flush) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO queued at issue, checked on done.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] srca = 32'h0;
  logic [31:0] srcb = 32'h0;
  logic [31:0] hi, lo;
  logic        busy, done;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  ex_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .flush (flush),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      OP_MULT:  return sa * sb;
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Pop and compare whenever the unit reports a result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done === 1'b1) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq({e.tag, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
        check_eq({e.tag, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
      end
    end
  end

  // Issue an op at the current negedge and wait (bounded) for done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit timing);
    exp_t x;
    int   busy_cyc;
    int   guard;
    x.tag = tag; x.hi = ehi; x.lo = elo;
    sb_q.push_back(x);
    last_hi = ehi; last_lo = elo;
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0; guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_done_seen"}, {63'h0, done}, 64'd1);
    if (timing) begin
      check_eq({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
      check_eq({tag, "_busy_at_done"}, {63'h0, busy}, 64'd0);
      @(negedge clk);
      check_eq({tag, "_done_width"}, {63'h0, done}, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] m;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          seen0;

    repeat (2) @(negedge clk);
    check_eq("rst_hi", {32'h0, hi}, 64'h0);
    check_eq("rst_lo", {32'h0, lo}, 64'h0);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_done", {63'h0, done}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    @(negedge clk);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    @(negedge clk);
    run_op("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom;
      m  = model(ro, ra, rb);
      run_op("rand", ro, ra, rb, m[63:32], m[31:0], 1'b0);
    end

    // Reserved opcode and flush-with-MTHI are both no-ops.
    @(negedge clk);
    start = 1'b1; op = 3'b110; srca = 32'hDEAD0000;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTHI; srca = 32'h9999;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_eq("noop_busy", {63'h0, busy}, 64'h0);
    check_eq("noop_hi", {32'h0, hi}, {32'h0, last_hi});
    check_eq("noop_lo", {32'h0, lo}, {32'h0, last_lo});

    // Preload, start MULT, ignored start at cycle 5, flush at cycle 10.
    start = 1'b1; op = OP_MTHI; srca = 32'h1234;
    @(negedge clk);
    check_eq("mthi", {32'h0, hi}, 64'h1234);
    op = OP_MTLO; srca = 32'h5678;
    @(negedge clk);
    check_eq("mtlo", {32'h0, lo}, 64'h5678);
    check_eq("mt_busy", {63'h0, busy}, 64'h0);
    op = OP_MULT; srca = 32'd3; srcb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; srca = 32'd9; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("busy_before_flush", {63'h0, busy}, 64'h1);
    seen0 = done_seen;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", {63'h0, busy}, 64'h0);
    check_eq("flush_hi", {32'h0, hi}, 64'h1234);
    check_eq("flush_lo", {32'h0, lo}, 64'h5678);
    repeat (40) @(negedge clk);
    check_eq("flush_no_done", 64'(done_seen - seen0), 64'h0);
    check_eq("flush_idle", {63'h0, busy}, 64'h0);
    check_eq("flush_hi_hold", {32'h0, hi}, 64'h1234);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = OP_DIV; srca = 32'd100; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_hi", {32'h0, hi}, 64'h0);
    check_eq("arst_lo", {32'h0, lo}, 64'h0);
    check_eq("arst_busy", {63'h0, busy}, 64'h0);
    check_eq("arst_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; op = OP_MTLO; srca = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    check_eq("post_rst_mtlo", {32'h0, lo}, 64'hABCD);
    check_eq("post_rst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    check_eq("post_rst_busy2", {63'h0, busy}, 64'h0);
    check_eq("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage. It consumes operands and an operation code issued from the ID/EX pipeline register.
- Computes 64-bit products and 32-bit quotient/remainder into the architectural HI/LO registers.
- Returns a busy/stall indication toward the hazard logic while a long-latency operation is in flight.
- Supports interrupt-driven abort.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation valid this cycle, from EX control.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, treated as no-op.
- srca  input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO source).
- srcb  input  WIDTH  rt operand (multiplier or divisor).
- flush  input  1  interrupt/flush; aborts the in-flight operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high while the FSM is not IDLE; the hazard unit stalls MFHI/MFLO and any new start on it.
- done  output  1  one-cycle pulse when hi/lo receive a MULT/DIV result.

Behaviour:
- Reset values (applied asynchronously): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, flush=0:
  - Latch operand magnitudes (absolute values for signed ops) and result-sign flags.
  - Clear the accumulator and set counter=0; go to RUN.
- IDLE, start=1, op=MTHI: hi<=srca at the same edge. MTLO: lo<=srca. FSM stays IDLE; busy and done stay 0.
- RUN: one iteration per cycle, 32 cycles.
  - Multiply: shift-add radix-2 over the 64-bit accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle.
  - At the edge where counter==WIDTH-1, go to FIX.
- FIX: one cycle.
  - Apply sign correction. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Write hi/lo, go to IDLE, and drive done=1 for the following cycle only.
- Latency: start sampled at edge 0 → hi/lo valid and done=1 after edge 33. busy is high for exactly 33 cycles (after edge 0 through edge 33).
- Divide by zero: same latency; lo=all ones, hi=dividend (the raw srca value).
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the unsigned-magnitude path and needs no special case.
- start while busy: ignored; no state change. The bench flags it as a protocol violation.
- flush=1 in RUN or FIX: next edge → IDLE. hi/lo keep their pre-operation values; no done pulse.
- flush=1 and start=1 together in IDLE: flush wins; nothing is accepted, including MTHI/MTLO.
- Reset mid-operation: immediate return to the reset values; no done.
- Width rules:
  - Magnitude of 0x80000000 is held as unsigned 0x80000000.
  - Accumulator is 2*WIDTH+1 bits so divide compare/subtract has no overflow.
  - hi = product[63:32] or remainder; lo = product[31:0] or quotient.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT … OP_MTLO),
  - FSM state encodings (S_IDLE, S_RUN, S_FIX),
  - the WIDTH default.
- One sub-module, muldiv_core: the iteration datapath (accumulator, shift-add/shift-subtract step, counter, sign correction).
- The FSM, the HI/LO registers, and flush/MT handling stay in ex_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly one cycle, after edge 33; busy is high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21).
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Back-to-back DIVU 100/7 → lo=14, hi=2. Second start is issued the cycle after done.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload MTHI 0x1234 / MTLO 0x5678, then start MULT:
  - Pulse start with different operands at cycle 5 → ignored.
  - flush at cycle 10 → busy=0 next cycle, hi=0x1234, lo=0x5678, no done.
- Start DIV, assert reset asynchronously mid-RUN (between edges) → hi=lo=0, busy=0, done=0 immediately. After release, MTLO 0xABCD → lo=0xABCD at the next edge; busy never rises.
